// File: rtl/sync_bus_sched.sv
// sync_bus_sched
//
// Round-robin scheduler that time-multiplexes NUM_CH status words onto one
// shared bus-synchronizer input. It captures the winning word, then holds it
// stable for HOLD_CYCLES cycles so it can cross into the receiving domain.
// bus_tog flips on every capture, so the receiver can spot a new word even
// when its value repeats.
//
// Ports
//   clk       in   single clock, rising edge
//   resetn    in   asynchronous active-low reset
//   en        in   high: new grants allowed; low: finish the hold, then stall
//   ch_req    in   [NUM_CH]        per-channel request level
//   ch_data   in   [NUM_CH*WIDTH]  channel i word at [i*WIDTH +: WIDTH]
//   ch_ack    out  [NUM_CH]        one-cycle pulse: that channel's word was captured
//   bus_data  out  [WIDTH]         captured word fed to the synchronizer
//   bus_idx   out  [IDXW]          channel index of bus_data
//   bus_tog   out                  flips on every new word
//   busy      out                  high while a word is being held

module sync_bus_sched #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  localparam int unsigned IDXW       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_ack,
  output logic [WIDTH-1:0]        bus_data,
  output logic [IDXW-1:0]         bus_idx,
  output logic                    bus_tog,
  output logic                    busy
);

  // Counter only needs to hold HOLD_CYCLES-1.
  localparam int unsigned CNTW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  state_e            state_q;
  logic [CNTW-1:0]   hold_cnt_q;
  logic [IDXW-1:0]   last_grant_q;
  logic [NUM_CH-1:0] ch_ack_q;
  logic [WIDTH-1:0]  bus_data_q;
  logic [IDXW-1:0]   bus_idx_q;
  logic              bus_tog_q;

  // Per-channel words, unpacked for indexed selection by the winner.
  logic [WIDTH-1:0] ch_words [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_words[g] = ch_data[g*WIDTH +: WIDTH];
  end

  // Round-robin arbiter: search from last_grant+1 upward, wrapping, so the
  // last winner is checked last. A lone requester therefore still wins.
  logic              win_found;
  logic [IDXW-1:0]   win_idx;
  logic [31:0]       last_ext;
  logic [31:0]       cand;
  logic [IDXW-1:0]   cand_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant_q;
    last_ext  = 32'(last_grant_q);
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      cand = last_ext + off;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      cand_idx = IDXW'(cand);
      if (!win_found && ch_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      hold_cnt_q   <= '0;
      last_grant_q <= IDXW'(NUM_CH - 1);
      ch_ack_q     <= '0;
      bus_data_q   <= '0;
      bus_idx_q    <= '0;
      bus_tog_q    <= 1'b0;
    end else begin
      // Ack is a single-cycle pulse; only a grant edge sets a bit.
      ch_ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (en && win_found) begin
            state_q           <= StHold;
            hold_cnt_q        <= CNTW'(HOLD_CYCLES - 1);
            last_grant_q      <= win_idx;
            ch_ack_q[win_idx] <= 1'b1;
            bus_data_q        <= ch_words[win_idx];
            bus_idx_q         <= win_idx;
            bus_tog_q         <= ~bus_tog_q;
          end
        end
        StHold: begin
          // Requests, data and en are ignored until the hold has run out.
          if (hold_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q - CNTW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ch_ack   = ch_ack_q;
  assign bus_data = bus_data_q;
  assign bus_idx  = bus_idx_q;
  assign bus_tog  = bus_tog_q;
  assign busy     = (state_q == StHold);

endmodule
